// File: rtl/tdc_digital_frontend.sv
// Digital back-end for the ADPLL TDC: samples ripple count and Johnson-coded taps,
// decodes the combined phase word, differentiates it and accumulates the unwrapped phase.
// Optional bubble detection output is compiled in with `define TDC_BUBBLE_DET_EN.
module tdc_digital_frontend #(
    parameter int RC_W   = 7,
    parameter int N_PH   = 16,
    parameter int FRAC_W = $clog2(2*N_PH),
    parameter int ACC_W  = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   pd,
    input  logic                   acc_clr,
    input  logic [RC_W-1:0]        ripple_count,
    input  logic [N_PH-1:0]        phase,
    output logic [RC_W+FRAC_W-1:0] tdc_delta,
    output logic [ACC_W-1:0]       tdc_phase,
`ifdef TDC_BUBBLE_DET_EN
    output logic                   bubble_err,
`endif
    output logic                   tdc_valid
);

    localparam int DW = RC_W + FRAC_W;
    // 2*N_PH is exactly 2^FRAC_W because N_PH is a power of two.
    localparam logic [FRAC_W:0] TWO_N = {1'b1, {FRAC_W{1'b0}}};

    logic [RC_W-1:0]   s1_rc;
    logic [N_PH-1:0]   s1_ph;
    logic              s1_vld;
    logic [DW-1:0]     s2_phi;
    logic              s2_vld;
    logic [DW-1:0]     phi_prev;
    logic              primed;

    logic [FRAC_W:0]   pc;
    logic [FRAC_W:0]   frac_full;
    logic [FRAC_W-1:0] frac;
    logic [DW-1:0]     delta_next;
    logic              emit;

    // Popcount-based decode keeps a single-bit bubble from causing a large phase error.
    always_comb begin
        pc = '0;
        for (int i = 0; i < N_PH; i++) begin
            pc = pc + (FRAC_W+1)'(s1_ph[i]);
        end
        frac_full = s1_ph[N_PH-1] ? (TWO_N - pc) : pc;
        frac      = frac_full[FRAC_W-1:0];
    end

    assign delta_next = s2_phi - phi_prev;
    assign emit       = s2_vld && primed;

`ifdef TDC_BUBBLE_DET_EN
    logic [N_PH-1:0] trans;
    logic [FRAC_W:0] tc;
    logic            s1_bub;
    logic            s2_bub;

    // A legal Johnson snapshot has at most two edges around the ring.
    always_comb begin
        trans = s1_ph ^ {s1_ph[0], s1_ph[N_PH-1:1]};
        tc    = '0;
        for (int i = 0; i < N_PH; i++) begin
            tc = tc + (FRAC_W+1)'(trans[i]);
        end
        s1_bub = (tc > (FRAC_W+1)'(2));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_bub     <= 1'b0;
            bubble_err <= 1'b0;
        end else if (pd) begin
            s2_bub     <= 1'b0;
            bubble_err <= 1'b0;
        end else begin
            if (s1_vld) s2_bub <= s1_bub;
            bubble_err <= emit && s2_bub;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_rc     <= '0;
            s1_ph     <= '0;
            s1_vld    <= 1'b0;
            s2_phi    <= '0;
            s2_vld    <= 1'b0;
            phi_prev  <= '0;
            primed    <= 1'b0;
            tdc_delta <= '0;
            tdc_phase <= '0;
            tdc_valid <= 1'b0;
        end else if (pd) begin
            // Power-down drops everything in flight; outputs keep their last values.
            s1_vld    <= 1'b0;
            s2_vld    <= 1'b0;
            primed    <= 1'b0;
            tdc_valid <= 1'b0;
        end else begin
            if (en) begin
                s1_rc <= ripple_count;
                s1_ph <= phase;
            end
            s1_vld <= en;

            s2_vld <= s1_vld;
            if (s1_vld) s2_phi <= {s1_rc, frac};

            if (s2_vld) begin
                phi_prev <= s2_phi;
                primed   <= 1'b1;
            end

            tdc_valid <= emit;
            if (emit) tdc_delta <= delta_next;

            if (acc_clr) begin
                tdc_phase <= emit ? ACC_W'(delta_next) : '0;
            end else if (emit) begin
                tdc_phase <= tdc_phase + ACC_W'(delta_next);
            end
        end
    end

endmodule

// File: tb/tb_tdc_digital_frontend.sv
// Self-checking bench for tdc_digital_frontend: transaction-level model plus directed scenarios.
module tb_tdc_digital_frontend;

    localparam int RC_W   = 7;
    localparam int N_PH   = 16;
    localparam int FRAC_W = $clog2(2*N_PH);
    localparam int ACC_W  = 24;
    localparam int DW     = RC_W + FRAC_W;
    localparam int DMASK  = (1 << DW) - 1;
    localparam int AMASK  = (1 << ACC_W) - 1;

    logic              clk;
    logic              rst;
    logic              en;
    logic              pd;
    logic              acc_clr;
    logic [RC_W-1:0]   ripple_count;
    logic [N_PH-1:0]   phase;
    logic [DW-1:0]     tdc_delta;
    logic [ACC_W-1:0]  tdc_phase;
    logic              tdc_valid;
`ifdef TDC_BUBBLE_DET_EN
    logic              bubble_err;
`endif

    tdc_digital_frontend #(
        .RC_W (RC_W),
        .N_PH (N_PH),
        .ACC_W(ACC_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .pd          (pd),
        .acc_clr     (acc_clr),
        .ripple_count(ripple_count),
        .phase       (phase),
        .tdc_delta   (tdc_delta),
        .tdc_phase   (tdc_phase),
`ifdef TDC_BUBBLE_DET_EN
        .bubble_err  (bubble_err),
`endif
        .tdc_valid   (tdc_valid)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // scoreboard counters
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model: each accepted sample becomes a transaction due two edges later
    typedef struct {
        int phi;
        bit bub;
        int due;
    } samp_t;

    samp_t pend[$];
    int    cyc        = 0;
    bit    model_live = 0;
    bit    m_primed   = 0;
    int    m_prev     = 0;
    int    m_delta    = 0;
    int    m_phase    = 0;
    bit    m_valid    = 0;
    bit    m_bub      = 0;

    function automatic int phi_of(input logic [RC_W-1:0] rc, input logic [N_PH-1:0] ph);
        int pc;
        int fr;
        pc = $countones(ph);
        fr = ph[N_PH-1] ? ((2*N_PH - pc) % (2*N_PH)) : pc;
        return (int'(rc) * 2 * N_PH + fr) & DMASK;
    endfunction

    function automatic bit bubble_of(input logic [N_PH-1:0] ph);
        int edges;
        edges = 0;
        for (int i = 0; i < N_PH; i++) begin
            if (ph[i] != ph[(i+1) % N_PH]) edges++;
        end
        return edges > 2;
    endfunction

    always @(posedge clk) begin
        samp_t s;
        bit    got;
        cyc++;
        model_live = 1;
        if (rst) begin
            pend.delete();
            m_primed = 0; m_phase = 0; m_delta = 0; m_valid = 0; m_bub = 0; m_prev = 0;
        end else if (pd) begin
            pend.delete();
            m_primed = 0; m_valid = 0; m_bub = 0;
        end else begin
            m_valid = 0;
            m_bub   = 0;
            got     = 0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                s   = pend.pop_front();
                got = 1;
            end
            if (got && m_primed) begin
                m_delta = (s.phi - m_prev) & DMASK;
                m_valid = 1;
                m_bub   = s.bub;
            end
            if (got) begin
                m_prev   = s.phi;
                m_primed = 1;
            end
            if (acc_clr) m_phase = 0;
            if (m_valid) m_phase = (m_phase + m_delta) & AMASK;
            if (en) pend.push_back('{phi: phi_of(ripple_count, phase), bub: bubble_of(phase), due: cyc + 2});
        end
    end

    // compare process: every cycle after the first edge
    always @(negedge clk) begin
        if (model_live) begin
            check("valid", 32'(tdc_valid), 32'(m_valid));
            check("delta", 32'(tdc_delta), 32'(m_delta));
            check("phase", 32'(tdc_phase), 32'(m_phase));
`ifdef TDC_BUBBLE_DET_EN
            check("bubble", 32'(bubble_err), 32'(m_bub));
`endif
        end
    end

    // driver: apply inputs after a falling edge, return after the next falling edge
    task automatic step(input int rc, input logic [N_PH-1:0] ph, input bit e, input bit p, input bit c);
        logic [31:0] r;
        r            = rc;
        ripple_count = r[RC_W-1:0];
        phase        = ph;
        en           = e;
        pd           = p;
        acc_clr      = c;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; pd = 1'b0; acc_clr = 1'b0;
        ripple_count = '0; phase = '0;

        // reset with random inputs
        for (int i = 0; i < 3; i++) begin
            step($urandom_range(0, 127), N_PH'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        check("rst_valid", 32'(tdc_valid), 32'd0);
        check("rst_delta", 32'(tdc_delta), 32'd0);
        check("rst_phase", 32'(tdc_phase), 32'd0);
        rst = 1'b0;

        // constant rate: +78 periods per clk, taps all zero
        for (int k = 0; k < 6; k++) begin
            step(78 * k, 16'h0000, 1, 0, 0);
            if (k == 2) check("prime_no_valid", 32'(tdc_valid), 32'd0);
            if (k == 3) begin
                check("first_valid", 32'(tdc_valid), 32'd1);
                check("first_delta", 32'(tdc_delta), 32'd2496);
                check("first_phase", 32'(tdc_phase), 32'd2496);
            end
        end
        idle(3);
        check("rate_phase", 32'(tdc_phase), 32'd12480);

        // tap decode: phi 160,168,176,184,192
        step(0, 16'h0000, 0, 1, 0);
        step(5, 16'h0000, 1, 0, 0);
        step(5, 16'h00FF, 1, 0, 0);
        step(5, 16'hFFFF, 1, 0, 0);
        step(5, 16'hFF00, 1, 0, 0);
        step(6, 16'h0000, 1, 0, 0);
        idle(3);
        check("tap_delta", 32'(tdc_delta), 32'd8);
        check("tap_phase", 32'(tdc_phase), 32'd12512);

        // ripple wrap: 120 -> 70
        step(0, 16'h0000, 0, 1, 0);
        step(120, 16'h0000, 1, 0, 0);
        step(70, 16'h0000, 1, 0, 0);
        idle(3);
        check("wrap_delta", 32'(tdc_delta), 32'd2496);
        check("wrap_phase", 32'(tdc_phase), 32'd15008);

        // power-down mid-stream
        step(0, 16'h0000, 0, 1, 0);
        for (int k = 0; k < 4; k++) step(78 * k, 16'h0000, 1, 0, 0);
        for (int k = 4; k < 8; k++) begin
            step(78 * k, 16'h0000, 1, 1, 0);
            if (k == 4) check("pd_valid_low", 32'(tdc_valid), 32'd0);
        end
        check("pd_phase_held", 32'(tdc_phase), 32'd17504);
        for (int k = 8; k < 12; k++) begin
            step(78 * k, 16'h0000, 1, 0, 0);
            if (k == 10) check("pd_reprime", 32'(tdc_valid), 32'd0);
        end
        idle(3);
        check("pd_resume_phase", 32'(tdc_phase), 32'd24992);

        // accumulator clear coinciding with a delta
        step(0, 16'h0000, 0, 1, 0);
        step(0, 16'h0000, 1, 0, 0);
        step(78, 16'h0000, 1, 0, 0);
        step(156, 16'h0000, 1, 0, 0);
        step(0, 16'h0000, 0, 0, 0);
        check("preclr_phase", 32'(tdc_phase), 32'd27488);
        step(0, 16'h0000, 0, 0, 1);
        check("clr_valid", 32'(tdc_valid), 32'd1);
        check("clr_phase", 32'(tdc_phase), 32'd2496);
        idle(1);
        check("postclr_phase", 32'(tdc_phase), 32'd2496);

        // illegal snapshot: frac 7 but two runs of ones
        step(0, 16'h0000, 0, 1, 0);
        step(0, 16'h0000, 1, 0, 0);
        step(0, 16'h00F7, 1, 0, 0);
        idle(2);
        check("bub_delta", 32'(tdc_delta), 32'd7);
`ifdef TDC_BUBBLE_DET_EN
        check("bub_flag", 32'(bubble_err), 32'd1);
`endif
        idle(2);

        // reset mid-operation
        for (int k = 0; k < 4; k++) step(78 * k, 16'h0000, 1, 0, 0);
        rst = 1'b1;
        step(0, 16'h0000, 1, 0, 0);
        check("midrst_valid", 32'(tdc_valid), 32'd0);
        check("midrst_phase", 32'(tdc_phase), 32'd0);
        check("midrst_delta", 32'(tdc_delta), 32'd0);
        rst = 1'b0;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
